// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - SPI-slave model of an 8-channel 12-bit SAR ADC (LTC2308-style framing).
// Optional build macro ADC_RESP_RAMP_EN replaces the external sample source with an internal ramp.
module adc_spi_responder #(
   parameter int DATA_W      = 12,
   parameter int CFG_W       = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              adc_cs,
   input  logic              adc_sclk,
   input  logic              adc_din,
   output logic              adc_dout,
   output logic              sample_req,
   output logic [2:0]        sample_ch,
   input  logic [DATA_W-1:0] sample_data,
   input  logic              sample_valid,
   output logic [CFG_W-1:0]  cfg_word,
   output logic              cfg_valid,
   output logic              frame_err,
   output logic              underrun
);
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CFG_N  = CNT_W'(CFG_W);
   localparam logic [CNT_W-1:0] DATA_N = CNT_W'(DATA_W);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t              state;
   logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, din_sync;
   logic                cs_r1, cs_r2, sclk_r1, sclk_r2, din_r1;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   shift_reg;
   logic [DATA_W-1:0]   hold;
   logic [CFG_W-1:0]    cfg_sr;
   logic [DATA_W-1:0]   load_word;
   logic [2:0]          new_ch;
   logic                cs_fall, cs_rise, sclk_rise, sclk_fall;

   // Sync flops reset to 0 so a frame already open when reset releases never looks like a cs fall.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cs_sync   <= '0;
         sclk_sync <= '0;
         din_sync  <= '0;
         cs_r1     <= 1'b0;
         cs_r2     <= 1'b0;
         sclk_r1   <= 1'b0;
         sclk_r2   <= 1'b0;
         din_r1    <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], adc_cs};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], adc_sclk};
         din_sync  <= {din_sync[SYNC_STAGES-2:0], adc_din};
         cs_r1     <= cs_sync[SYNC_STAGES-1];
         cs_r2     <= cs_r1;
         sclk_r1   <= sclk_sync[SYNC_STAGES-1];
         sclk_r2   <= sclk_r1;
         din_r1    <= din_sync[SYNC_STAGES-1];
      end
   end

   assign cs_fall   = cs_r2 & ~cs_r1;
   assign cs_rise   = ~cs_r2 & cs_r1;
   assign sclk_rise = ~sclk_r2 & sclk_r1;
   assign sclk_fall = sclk_r2 & ~sclk_r1;
   assign new_ch    = {cfg_sr[CFG_W-3], cfg_sr[CFG_W-4], cfg_sr[CFG_W-2]};

`ifdef ADC_RESP_RAMP_EN
   logic [DATA_W-4:0] ramp;
   wire unused_src = ^{sample_data, sample_valid};
   assign load_word = hold;
`else
   assign load_word = (sample_req && sample_valid) ? sample_data : hold;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         adc_dout   <= 1'b0;
         sample_req <= 1'b0;
         sample_ch  <= 3'd0;
         cfg_word   <= CFG_W'(6'b100010);
         cfg_valid  <= 1'b0;
         frame_err  <= 1'b0;
         underrun   <= 1'b0;
         hold       <= '0;
         cnt        <= '0;
         shift_reg  <= '0;
         cfg_sr     <= '0;
`ifdef ADC_RESP_RAMP_EN
         ramp       <= '0;
`endif
      end else begin
         cfg_valid <= 1'b0;
         frame_err <= 1'b0;
         underrun  <= 1'b0;
`ifndef ADC_RESP_RAMP_EN
         if (sample_req && sample_valid) begin
            hold       <= sample_data;
            sample_req <= 1'b0;
         end
`endif
         case (state)
            IDLE: begin
               adc_dout <= 1'b0;
               if (cs_fall) begin
                  state     <= SHIFT;
                  adc_dout  <= load_word[DATA_W-1];
                  shift_reg <= {load_word[DATA_W-2:0], 1'b0};
                  cnt       <= '0;
                  cfg_sr    <= '0;
`ifndef ADC_RESP_RAMP_EN
                  underrun  <= sample_req & ~sample_valid;
`endif
               end
            end
            SHIFT: begin
               if (cs_rise) begin
                  state    <= IDLE;
                  adc_dout <= 1'b0;
                  if (cnt >= CFG_N) begin
                     cfg_word   <= cfg_sr;
                     cfg_valid  <= 1'b1;
                     sample_ch  <= new_ch;
`ifdef ADC_RESP_RAMP_EN
                     hold       <= {new_ch, ramp};
                     ramp       <= ramp + 1'b1;
`else
                     sample_req <= 1'b1;
`endif
                  end
                  if (cnt != DATA_N)
                     frame_err <= 1'b1;
               end else if (sclk_rise) begin
                  if (cnt < CFG_N)
                     cfg_sr <= {cfg_sr[CFG_W-2:0], din_r1};
                  if (cnt < DATA_N)
                     cnt <= cnt + 1'b1;
               end else if (sclk_fall) begin
                  if (cnt < DATA_N) begin
                     adc_dout  <= shift_reg[DATA_W-1];
                     shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                  end else begin
                     adc_dout <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb/tb_adc_spi_responder.sv - scoreboard bench for adc_spi_responder (both ramp and handshake builds).
module tb_adc_spi_responder;
   localparam int SYNC = 2;
   localparam int HALF = 8;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        adc_cs = 1'b1, adc_sclk = 1'b0, adc_din = 1'b0;
   logic        adc_dout;
   logic        sample_req;
   logic [2:0]  sample_ch;
   logic [11:0] sample_data = '0;
   logic        sample_valid = 1'b0;
   logic [5:0]  cfg_word;
   logic        cfg_valid, frame_err, underrun;

   int n_checks = 0, n_fail = 0;
   int n_cfg = 0, n_err = 0, n_und = 0, n_dout_hi = 0;
   logic [11:0] exp_q[$];
   logic [11:0] rx;

   adc_spi_responder #(.DATA_W(12), .CFG_W(6), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .reset_n(reset_n), .adc_cs(adc_cs), .adc_sclk(adc_sclk), .adc_din(adc_din),
      .adc_dout(adc_dout), .sample_req(sample_req), .sample_ch(sample_ch),
      .sample_data(sample_data), .sample_valid(sample_valid), .cfg_word(cfg_word),
      .cfg_valid(cfg_valid), .frame_err(frame_err), .underrun(underrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cfg_valid) n_cfg++;
      if (frame_err) n_err++;
      if (underrun)  n_und++;
      if (adc_dout)  n_dout_hi++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr_counts();
      n_cfg = 0; n_err = 0; n_und = 0; n_dout_hi = 0;
   endtask

   task automatic sclk_pulse();
      adc_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      adc_sclk = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   // One master frame of n clocks; optionally presents sample_valid exactly in the cs-fall cycle.
   task automatic do_frame(input logic [5:0] cfg, input int n, input bit byp,
                           input logic [11:0] bdata, output logic [11:0] got);
      got = '0;
      clr_counts();
      adc_cs = 1'b0;
      repeat (SYNC + 1) @(negedge clk);
      if (byp) begin
         sample_data = bdata;
         sample_valid = 1'b1;
      end
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < n; i++) begin
         adc_din = (i < 6) ? cfg[5 - i] : 1'b0;
         @(negedge clk);
         got = {got[10:0], adc_dout};
         sclk_pulse();
      end
      adc_cs = 1'b1;
      repeat (2 * HALF) @(negedge clk);
   endtask

   task automatic pop_check(input string tag, input logic [11:0] got);
      logic [11:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         check(tag, 32'(got), 32'(e));
      end
   endtask

   // Waveform source: waits (bounded) for a request, checks channel, answers with data.
   task automatic serve(input logic [2:0] ch, input logic [11:0] d);
      int t = 0;
      while (!sample_req && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("serve_req_seen", 32'(sample_req), 32'd1);
      check("serve_ch", 32'(sample_ch), 32'(ch));
      sample_data = d;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
      check("req_dropped", 32'(sample_req), 32'd0);
   endtask

   initial begin
      repeat (4) @(negedge clk);
      check("rst_dout", 32'(adc_dout), 32'd0);
      check("rst_cfg_word", 32'(cfg_word), 32'h22);
      check("rst_req", 32'(sample_req), 32'd0);
      check("rst_ch", 32'(sample_ch), 32'd0);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_dout", 32'(adc_dout), 32'd0);

`ifdef ADC_RESP_RAMP_EN
      exp_q.push_back(12'h000);
      exp_q.push_back(12'h400);
      exp_q.push_back(12'h401);
      exp_q.push_back(12'h402);
      for (int k = 0; k < 4; k++) begin
         do_frame(6'b100110, 12, 1'b0, 12'h000, rx);
         pop_check("ramp_rx", rx);
         check("ramp_cfg_valid", 32'(n_cfg), 32'd1);
         check("ramp_ch", 32'(sample_ch), 32'd2);
         check("ramp_req", 32'(sample_req), 32'd0);
      end
`else
      // A: first frame returns reset hold, requests CH1
      exp_q.push_back(12'h000);
      do_frame(6'b110010, 12, 1'b0, 12'h000, rx);
      pop_check("A_rx", rx);
      check("A_cfg_valid", 32'(n_cfg), 32'd1);
      check("A_frame_err", 32'(n_err), 32'd0);
      check("A_cfg_word", 32'(cfg_word), 32'h32);
      check("A_req", 32'(sample_req), 32'd1);
      serve(3'd1, 12'hA5C);
      exp_q.push_back(12'hA5C);

      do_frame(6'b110010, 12, 1'b0, 12'h000, rx);
      pop_check("B_rx", rx);
      check("B_frame_err", 32'(n_err), 32'd0);
      check("B_underrun", 32'(n_und), 32'd0);
      serve(3'd1, 12'h3C7);

      // C: short frame reads 4 MSBs, errors, keeps config
      exp_q.push_back(12'h3C7 >> 8);
      do_frame(6'b000000, 4, 1'b0, 12'h000, rx);
      pop_check("C_rx", rx);
      check("C_frame_err", 32'(n_err), 32'd1);
      check("C_cfg_valid", 32'(n_cfg), 32'd0);
      check("C_cfg_word", 32'(cfg_word), 32'h32);
      check("C_req", 32'(sample_req), 32'd0);

      // D: 8-clock frame still accepts config, flags error
      exp_q.push_back(12'h3C7 >> 4);
      do_frame(6'b111110, 8, 1'b0, 12'h000, rx);
      pop_check("D_rx", rx);
      check("D_cfg_valid", 32'(n_cfg), 32'd1);
      check("D_frame_err", 32'(n_err), 32'd1);
      check("D_ch", 32'(sample_ch), 32'd7);
      check("D_cfg_word", 32'(cfg_word), 32'h3E);
      check("D_req", 32'(sample_req), 32'd1);

      // E: request left pending -> underrun, stale value, request retargeted to CH1
      exp_q.push_back(12'h3C7);
      do_frame(6'b110010, 12, 1'b0, 12'h000, rx);
      pop_check("E_rx", rx);
      check("E_underrun", 32'(n_und), 32'd1);
      check("E_req", 32'(sample_req), 32'd1);
      check("E_ch", 32'(sample_ch), 32'd1);

      // F: sample_valid in the cs-fall cycle bypasses into the frame
      exp_q.push_back(12'h6E1);
      do_frame(6'b110010, 12, 1'b1, 12'h6E1, rx);
      pop_check("F_rx", rx);
      check("F_underrun", 32'(n_und), 32'd0);
      check("F_frame_err", 32'(n_err), 32'd0);

      // G: reset at bit 5 of a frame, released with cs still low
      adc_cs = 1'b0;
      repeat (2 * HALF) @(negedge clk);
      for (int i = 0; i < 5; i++) sclk_pulse();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("G_rst_dout", 32'(adc_dout), 32'd0);
      check("G_rst_cfg_word", 32'(cfg_word), 32'h22);
      check("G_rst_req", 32'(sample_req), 32'd0);
      reset_n = 1'b1;
      clr_counts();
      for (int i = 0; i < 6; i++) sclk_pulse();
      adc_cs = 1'b1;
      repeat (2 * HALF) @(negedge clk);
      check("G_dout_quiet", 32'(n_dout_hi), 32'd0);
      check("G_no_err", 32'(n_err), 32'd0);
      check("G_no_cfg", 32'(n_cfg), 32'd0);
      exp_q.push_back(12'h000);
      do_frame(6'b110010, 12, 1'b0, 12'h000, rx);
      pop_check("G_rx", rx);
      check("G_underrun", 32'(n_und), 32'd0);
`endif
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- SPI-slave model of the board's 8-channel 12-bit SAR ADC (LTC2308-style framing). It sits on the far end of the adc_cs/adc_sclk/adc_din/adc_dout link and answers the FPGA-side ADC master in loopback and self-test builds.
- Decodes the 6-bit config word shifted in on adc_din.
- Requests a sample for the selected channel from a waveform source.
- Shifts that sample out MSB-first on adc_dout during the next frame.

Parameters:
- DATA_W, 12, conversion result width.
- CFG_W, 6, config word width; bit order S/D, O/S, S1, S0, UNI, SLP.
- SYNC_STAGES, 2, synchroniser depth on adc_cs, adc_sclk and adc_din (minimum 2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- adc_cs  in  1  frame select, active low; its rising edge is CONVST.
- adc_sclk  in  1  serial clock, mode 0.
- adc_din  in  1  config bits, sampled on sclk rise.
- adc_dout  out  1  result bits, changed on sclk fall.
- sample_req  out  1  level; holds until sample_valid.
- sample_ch  out  3  channel requested.
- sample_data  in  DATA_W  sample for sample_ch.
- sample_valid  in  1  accepts sample_data while sample_req=1.
- cfg_word  out  CFG_W  last accepted config.
- cfg_valid  out  1  one-cycle pulse when cfg_word updates.
- frame_err  out  1  one-cycle pulse on a malformed frame.
- underrun  out  1  one-cycle pulse when a frame starts with a request still pending.

Behaviour:
- Reset values: adc_dout=0, sample_req=0, sample_ch=0, cfg_word=6'b100010 (single-ended, unipolar, CH0), cfg_valid=0, frame_err=0, underrun=0, hold register=0, bit counter=0, state IDLE.
- Input path: adc_cs, adc_sclk and adc_din pass through SYNC_STAGES flops; edges are detected on the synchronised signals.
- Timing: adc_dout updates SYNC_STAGES+2 clk cycles after the pin edge. The master must hold each sclk phase for at least SYNC_STAGES+3 clk cycles.
- FSM states: IDLE, SHIFT.
- IDLE → SHIFT on cs fall:
  - Load shift register from the hold register; drive the MSB on adc_dout.
  - Clear the bit counter.
  - If sample_req=1 and sample_valid=0: pulse underrun and send the stale hold value.
  - If sample_valid=1 in that same cycle: bypass sample_data straight into the shift register; no underrun.
- In SHIFT, sclk rise:
  - While count<CFG_W, shift adc_din into the cfg shift register.
  - Increment count, saturating at DATA_W.
- In SHIFT, sclk fall: shift the next bit to adc_dout while count<DATA_W. After DATA_W bits, adc_dout=0.
- SHIFT → IDLE on cs rise:
  - If count≥CFG_W: cfg_word <= captured bits; pulse cfg_valid; assert sample_req with sample_ch={S1,S0,O/S} (e.g. O/S=1,S1=0,S0=0 → CH1; O/S=1,S1=1,S0=1 → CH7).
  - If count<CFG_W: cfg_word unchanged; no request.
  - If count≠DATA_W: pulse frame_err.
  - adc_dout=0 while in IDLE.
- Request handshake:
  - On sample_req=1 and sample_valid=1: hold register <= sample_data; sample_req drops the next cycle.
  - A new request while one is pending overwrites sample_ch and keeps sample_req=1.
  - sample_valid while sample_req=0 is ignored.
- Simultaneous events:
  - A cs edge takes priority over an sclk edge in the same cycle; that sclk edge is ignored.
  - sclk edges in IDLE are ignored.
- The result returned in each frame always belongs to the config of the previous frame (pipelined, as on the real part).
- Reset mid-frame:
  - All state returns to reset values immediately (asynchronous).
  - After reset deasserts, a frame already in progress (cs low) is ignored until cs returns high and then falls again.

Optional Feature:
- Macro: ADC_RESP_RAMP_EN.
- Defined:
  - sample_data and sample_valid are ignored; sample_req stays 0.
  - On each accepted config, the hold register <= {sample_ch, ramp[DATA_W-4:0]}, where ramp is a counter reset to 0 that increments once per accepted config and wraps.
  - Gives self-checking data with no waveform source.
- Undefined: external handshake as described above.

Test Plan:
- Reset, cs held high → adc_dout=0, cfg_word=6'h22, sample_req=0; first frame returns 12'h000.
- Frame with din=6'b110010, 12 clocks → cfg_valid pulse, sample_ch=1, sample_req=1. Source returns 12'hA5C. Next frame → dout bits 1010_0101_1100; frame_err=0.
- Frame of only 4 clocks → frame_err pulse, no cfg_valid, cfg_word unchanged, sample_req unchanged.
- Frame of 8 clocks with din=6'b111110 → cfg_valid pulse, sample_ch=7, frame_err pulse.
- sample_valid withheld, next cs fall → underrun pulse, previous value resent.
  - Repeat with sample_valid asserted in the cs-fall cycle → new value sent, no underrun.
- Assert reset_n low at bit 5 of a frame, release with cs still low → adc_dout stays 0 until cs rises and falls again; that frame returns 12'h000. With ADC_RESP_RAMP_EN, three CH2 frames → returned results 12'h400, 12'h401, 12'h402.
